adc_to_opfb_hls_deadlock_reporter: RTL and testbench

- Consumer end of the HLS dataflow deadlock monitor interface. It receives the monitor's `block` flag and its per-channel `axis_block_info` vector.
- Qualifies a deadlock as `block` held for THRESH consecutive cycles. On qualification it latches the info vector and a free-running cycle timestamp, and raises a sticky `deadlock` flag.
- Emits one framed report over an AXI4-Stream byte master, for debug capture by the PS/ILA path.
- Sits beside the adc_to_opfb dataflow instance, in simulation/debug builds.

---
 rtl/adc_to_opfb_hls_deadlock_reporter_if.sv | 26 ++
 rtl/adc_to_opfb_hls_deadlock_reporter.sv | 139 +++++++++++++
 tb/tb_adc_to_opfb_hls_deadlock_reporter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_to_opfb_hls_deadlock_reporter_if.sv
// rtl/adc_to_opfb_hls_deadlock_reporter_if.sv - byte-wide AXI4-Stream report channel
// Ports (master view):
//   m_tdata  out 8  report byte
//   m_tvalid out 1  beat valid
//   m_tready in  1  sink ready
//   m_tlast  out 1  final byte of the report frame
interface adc_to_opfb_hls_deadlock_reporter_if;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;

    modport master (
        output m_tdata,
        output m_tvalid,
        output m_tlast,
        input  m_tready
    );

    modport slave (
        input  m_tdata,
        input  m_tvalid,
        input  m_tlast,
        output m_tready
    );
endinterface

// File: rtl/adc_to_opfb_hls_deadlock_reporter.sv
// rtl/adc_to_opfb_hls_deadlock_reporter.sv - qualifies HLS dataflow deadlocks and emits one framed report
// Purpose: counts consecutive cycles of the monitor's block flag; after THRESH
// of them it latches the channel info and a cycle timestamp, raises a sticky
// deadlock flag and streams the frame DE, info (LSB first), timestamp (LSB
// first). clear in the DONE state re-arms the block.
// Ports:
//   clock, reset          clock and asynchronous active-high reset
//   block                 monitor deadlock flag
//   axis_block_info       monitor per-channel info (INFO_W bits)
//   clear                 acknowledge pulse, honoured only after the frame is sent
//   deadlock              sticky qualified-deadlock flag
//   latched_info          info captured at qualification
//   latched_ts            timestamp captured at qualification
//   m_axis                byte-wide report stream (master)
module adc_to_opfb_hls_deadlock_reporter #(
    parameter int INFO_W = 9,
    parameter int THRESH = 16,
    parameter int TS_W   = 32
) (
    input  logic                                      clock,
    input  logic                                      reset,
    input  logic                                      block,
    input  logic [INFO_W-1:0]                         axis_block_info,
    input  logic                                      clear,
    output logic                                      deadlock,
    output logic [INFO_W-1:0]                         latched_info,
    output logic [TS_W-1:0]                           latched_ts,
    adc_to_opfb_hls_deadlock_reporter_if.master       m_axis
);

    localparam int INFO_B  = (INFO_W + 7) / 8;
    localparam int INFO_PW = 8 * INFO_B;
    localparam int TS_B    = TS_W / 8;
    localparam int FRAME_L = 1 + INFO_B + TS_B;
    localparam int FRAME_W = 8 * FRAME_L;
    localparam int RUN_W   = $clog2(THRESH + 1);
    localparam int IDX_W   = $clog2(FRAME_L + 1);

    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(THRESH - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_L - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        DONE
    } state_t;

    state_t            state;
    logic [RUN_W-1:0]  run;
    logic [TS_W-1:0]   ts;
    logic [IDX_W-1:0]  byte_idx;
    logic [7:0]        tdata_q;
    logic              tvalid_q;
    logic              tlast_q;

    logic [INFO_PW-1:0] info_ext;
    logic [FRAME_W-1:0] frame;
    logic [IDX_W-1:0]   next_idx;
    logic [7:0]         next_byte;

    // The frame is assembled from the latched registers, which are stable for
    // the whole SEND state, so byte k is simply a slice of this vector.
    always_comb begin
        info_ext  = INFO_PW'(latched_info);
        frame     = {latched_ts, info_ext, 8'hDE};
        next_idx  = byte_idx + 1'b1;
        next_byte = frame[{next_idx, 3'b000} +: 8];
    end

    assign m_axis.m_tdata  = tdata_q;
    assign m_axis.m_tvalid = tvalid_q;
    assign m_axis.m_tlast  = tlast_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            run          <= '0;
            ts           <= '0;
            byte_idx     <= '0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            deadlock     <= 1'b0;
            latched_info <= '0;
            latched_ts   <= '0;
        end else begin
            ts <= ts + 1'b1;
            case (state)
                IDLE: begin
                    if (block) begin
                        if (run == RUN_LAST) begin
                            // THRESH-th consecutive high sample: capture with
                            // the pre-increment timestamp and start the frame.
                            latched_info <= axis_block_info;
                            latched_ts   <= ts;
                            deadlock     <= 1'b1;
                            tvalid_q     <= 1'b1;
                            tdata_q      <= 8'hDE;
                            tlast_q      <= 1'b0;
                            byte_idx     <= '0;
                            run          <= '0;
                            state        <= SEND;
                        end else begin
                            run <= run + 1'b1;
                        end
                    end else begin
                        run <= '0;
                    end
                end
                SEND: begin
                    if (tvalid_q && m_axis.m_tready) begin
                        if (byte_idx == IDX_LAST) begin
                            tvalid_q <= 1'b0;
                            tlast_q  <= 1'b0;
                            state    <= DONE;
                        end else begin
                            byte_idx <= next_idx;
                            tdata_q  <= next_byte;
                            tlast_q  <= (next_idx == IDX_LAST);
                        end
                    end
                end
                DONE: begin
                    // block is ignored here so a persisting deadlock is not
                    // reported twice; only clear re-arms the counter.
                    if (clear) begin
                        deadlock <= 1'b0;
                        run      <= '0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_to_opfb_hls_deadlock_reporter.sv
// tb/tb_adc_to_opfb_hls_deadlock_reporter.sv - self-checking bench for the deadlock reporter
module tb_adc_to_opfb_hls_deadlock_reporter;

    localparam int INFO_W  = 9;
    localparam int THRESH  = 16;
    localparam int TS_W    = 32;
    localparam int FRAME_L = 7;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              block = 1'b0;
    logic              clear = 1'b0;
    logic [INFO_W-1:0] info  = '0;
    logic              deadlock;
    logic [INFO_W-1:0] latched_info;
    logic [TS_W-1:0]   latched_ts;

    adc_to_opfb_hls_deadlock_reporter_if axis();

    adc_to_opfb_hls_deadlock_reporter #(
        .INFO_W(INFO_W),
        .THRESH(THRESH),
        .TS_W  (TS_W)
    ) u_dut (
        .clock          (clock),
        .reset          (reset),
        .block          (block),
        .axis_block_info(info),
        .clear          (clear),
        .deadlock       (deadlock),
        .latched_info   (latched_info),
        .latched_ts     (latched_ts),
        .m_axis         (axis)
    );

    always #5 clock = ~clock;

    // Reference cycle count: value the DUT samples at the next rising edge.
    logic [TS_W-1:0] model_ts;
    always @(posedge clock or posedge reset) begin
        if (reset) model_ts <= '0;
        else       model_ts <= model_ts + 1;
    end

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } beat_t;

    beat_t sb[$];
    int total = 0;
    int bad   = 0;

    task automatic push_frame(input logic [INFO_W-1:0] inf, input logic [TS_W-1:0] t);
        beat_t b;
        logic [15:0] ie;
        ie = {7'd0, inf};
        b.d = 8'hDE; b.l = 1'b0; sb.push_back(b);
        for (int k = 0; k < 2; k++) begin
            b.d = ie[8*k +: 8]; b.l = 1'b0; sb.push_back(b);
        end
        for (int k = 0; k < 4; k++) begin
            b.d = t[8*k +: 8]; b.l = (k == 3); sb.push_back(b);
        end
    endtask

    // Called at the falling edge where the first byte is presented.
    task automatic collect_frame(input bit bp, output int cycles);
        int       nx = 0;
        int       i  = 0;
        bit       stall = 1'b0;
        logic [7:0] pd = '0;
        logic     pl = 1'b0;
        beat_t    e;
        bit [4:0] pat = 5'b10010;
        while (nx < FRAME_L && i < 200) begin
            axis.m_tready = bp ? pat[i % 5] : 1'b1;
            total++;
            if (axis.m_tvalid !== 1'b1) begin
                bad++;
                $display("FAIL tvalid_in_frame got=%b want=1 beat=%0d", axis.m_tvalid, nx);
            end
            if (stall) begin
                total++;
                if (axis.m_tdata !== pd || axis.m_tlast !== pl) begin
                    bad++;
                    $display("FAIL stall_hold got=%h/%b want=%h/%b", axis.m_tdata, axis.m_tlast, pd, pl);
                end
            end
            if (axis.m_tvalid === 1'b1 && axis.m_tready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat got=%h want=none", axis.m_tdata);
                end else begin
                    e = sb.pop_front();
                    if (axis.m_tdata !== e.d || axis.m_tlast !== e.l) begin
                        bad++;
                        $display("FAIL beat%0d got=%h/%b want=%h/%b", nx, axis.m_tdata, axis.m_tlast, e.d, e.l);
                    end
                end
                nx++;
            end
            stall = (axis.m_tvalid === 1'b1) && !axis.m_tready;
            pd = axis.m_tdata;
            pl = axis.m_tlast;
            i++;
            @(negedge clock);
        end
        cycles = i;
        axis.m_tready = 1'b0;
        total++;
        if (nx != FRAME_L) begin
            bad++;
            $display("FAIL frame_len got=%0d want=%0d", nx, FRAME_L);
        end
        total++;
        if (axis.m_tvalid !== 1'b0 || axis.m_tlast !== 1'b0) begin
            bad++;
            $display("FAIL frame_end got=%b/%b want=0/0", axis.m_tvalid, axis.m_tlast);
        end
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        total++;
        if (deadlock !== 1'b0) begin
            bad++;
            $display("FAIL clear_done got=%b want=0", deadlock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; block = 1'b0; clear = 1'b0; info = '0; axis.m_tready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        total++;
        if (deadlock !== 1'b0 || latched_info !== '0 || latched_ts !== '0 ||
            axis.m_tvalid !== 1'b0 || axis.m_tlast !== 1'b0 || axis.m_tdata !== 8'h00) begin
            bad++;
            $display("FAIL reset_state got=%b %h %h %b %b %h want=all zero", deadlock, latched_info,
                     latched_ts, axis.m_tvalid, axis.m_tlast, axis.m_tdata);
        end
        reset = 1'b0;
    endtask

    task automatic test_run_threshold();
        logic [TS_W-1:0] t0;
        int cyc;
        block = 1'b1; info = 9'h0A5;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clock);
            total++;
            if (deadlock !== 1'b0) begin
                bad++;
                $display("FAIL thr_first_burst k=%0d got=%b want=0", k, deadlock);
            end
        end
        block = 1'b0; info = '0;
        @(negedge clock);
        total++;
        if (deadlock !== 1'b0) begin
            bad++;
            $display("FAIL thr_gap got=%b want=0", deadlock);
        end
        block = 1'b1; info = 9'h0A5; t0 = model_ts;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            total++;
            if (deadlock !== (k == 16) || axis.m_tvalid !== (k == 16)) begin
                bad++;
                $display("FAIL thr_second_burst k=%0d got=%b/%b want=%b", k, deadlock, axis.m_tvalid, (k == 16));
            end
        end
        push_frame(9'h0A5, t0 + 15);
        block = 1'b0; info = '0;
        collect_frame(1'b0, cyc);
        total++;
        if (deadlock !== 1'b1 || latched_info !== 9'h0A5 || latched_ts !== t0 + 15) begin
            bad++;
            $display("FAIL thr_latched got=%b %h %0d want=1 0a5 %0d", deadlock, latched_info, latched_ts, t0 + 15);
        end
        clear_pulse();
    endtask

    task automatic test_frame_content();
        int cyc;
        test_reset();
        for (int g = 0; g < 1000 && model_ts != 100; g++) @(negedge clock);
        block = 1'b1; info = 9'h1FB;
        for (int k = 1; k <= 16; k++) @(negedge clock);
        total++;
        if (deadlock !== 1'b1 || latched_ts !== 32'd115 || latched_info !== 9'h1FB) begin
            bad++;
            $display("FAIL frame_capture got=%b %0d %h want=1 115 1fb", deadlock, latched_ts, latched_info);
        end
        push_frame(9'h1FB, 32'd115);
        block = 1'b0; info = '0;
        collect_frame(1'b0, cyc);
        total++;
        if (cyc != FRAME_L) begin
            bad++;
            $display("FAIL frame_back_to_back got=%0d cycles want=%0d", cyc, FRAME_L);
        end
        clear_pulse();
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [TS_W-1:0] t0;
        block = 1'b1; info = 9'h123; t0 = model_ts;
        for (int k = 1; k <= 16; k++) @(negedge clock);
        push_frame(9'h123, t0 + 15);
        block = 1'b0; info = '0;
        collect_frame(1'b1, cyc);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL bp_leftover got=%0d want=0", sb.size());
        end
        clear_pulse();
    endtask

    task automatic test_clear();
        int cyc;
        logic [TS_W-1:0] t0;
        logic [TS_W-1:0] t1;
        axis.m_tready = 1'b0;
        block = 1'b1; info = 9'h0F0; t0 = model_ts;
        for (int k = 1; k <= 16; k++) @(negedge clock);
        push_frame(9'h0F0, t0 + 15);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        total++;
        if (deadlock !== 1'b1 || axis.m_tvalid !== 1'b1 || axis.m_tdata !== 8'hDE) begin
            bad++;
            $display("FAIL clear_in_send got=%b %b %h want=1 1 de", deadlock, axis.m_tvalid, axis.m_tdata);
        end
        collect_frame(1'b0, cyc);
        @(negedge clock);
        @(negedge clock);
        total++;
        if (deadlock !== 1'b1 || axis.m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL done_hold got=%b %b want=1 0", deadlock, axis.m_tvalid);
        end
        clear_pulse();
        t1 = model_ts;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            total++;
            if (deadlock !== (k == 16)) begin
                bad++;
                $display("FAIL rearm k=%0d got=%b want=%b", k, deadlock, (k == 16));
            end
        end
        total++;
        if (latched_ts !== t1 + 15 || latched_info !== 9'h0F0) begin
            bad++;
            $display("FAIL rearm_ts got=%0d %h want=%0d 0f0", latched_ts, latched_info, t1 + 15);
        end
        push_frame(9'h0F0, t1 + 15);
        block = 1'b0; info = '0;
        collect_frame(1'b0, cyc);
        clear_pulse();
    endtask

    task automatic test_async_reset();
        int cyc;
        logic [TS_W-1:0] t0;
        axis.m_tready = 1'b1;
        block = 1'b1; info = 9'h155; t0 = model_ts;
        for (int k = 1; k <= 16; k++) @(negedge clock);
        block = 1'b0; info = '0;
        for (int k = 1; k <= 3; k++) @(negedge clock);
        total++;
        if (axis.m_tdata !== t0[7:0] + 8'd15 || axis.m_tvalid !== 1'b1) begin
            bad++;
            $display("FAIL byte3 got=%h/%b want=%h/1", axis.m_tdata, axis.m_tvalid, t0[7:0] + 8'd15);
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (axis.m_tvalid !== 1'b0 || deadlock !== 1'b0 || latched_info !== '0 ||
            latched_ts !== '0 || axis.m_tdata !== 8'h00) begin
            bad++;
            $display("FAIL async_reset got=%b %b %h %h %h want=all zero", axis.m_tvalid, deadlock,
                     latched_info, latched_ts, axis.m_tdata);
        end
        axis.m_tready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        block = 1'b1; info = 9'h0AA;
        for (int k = 1; k <= 16; k++) @(negedge clock);
        total++;
        if (deadlock !== 1'b1 || latched_ts !== 32'd15) begin
            bad++;
            $display("FAIL ts_restart got=%b %0d want=1 15", deadlock, latched_ts);
        end
        push_frame(9'h0AA, 32'd15);
        block = 1'b0; info = '0;
        collect_frame(1'b0, cyc);
        clear_pulse();
    endtask

    task automatic test_glitch();
        for (int ph = 0; ph < 3; ph++) begin
            block = (ph != 1); info = (ph != 1) ? 9'h0C3 : 9'h000;
            for (int k = 0; k < ((ph == 1) ? 1 : 10); k++) begin
                @(negedge clock);
                total++;
                if (deadlock !== 1'b0 || axis.m_tvalid !== 1'b0) begin
                    bad++;
                    $display("FAIL glitch ph=%0d k=%0d got=%b/%b want=0/0", ph, k, deadlock, axis.m_tvalid);
                end
            end
        end
        block = 1'b0; info = '0;
        @(negedge clock);
        total++;
        if (deadlock !== 1'b0 || axis.m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL glitch_end got=%b/%b want=0/0", deadlock, axis.m_tvalid);
        end
    endtask

    initial begin
        axis.m_tready = 1'b0;
        test_reset();
        test_run_threshold();
        test_frame_content();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
